// File: rtl/result_drain.sv
// result_drain: gathers the four core finish flags, then sweeps the result
// region of data memory through one read port and streams it out.
module result_drain #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32),
  parameter int unsigned       NUM_WORDS = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_process,
  input  logic              end_process_a,
  input  logic              end_process_b,
  input  logic              end_process_c,
  input  logic              end_process_d,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD,
    S_DONE
  } state_t;

  // NUM_WORDS = 2^ADDR_W folds to an all-ones start count
  localparam logic [ADDR_W-1:0] CNT_INIT =
    ADDR_W'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [3:0]          fin_q, fin_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;
  logic                rest;

  assign rest = (state_q == S_IDLE) ||
                (state_q == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      fin_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= fin_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  // clear beats set when both land on the same cycle
  always_comb begin
    fin_d = fin_q;
    if (!start_process) begin
      fin_d = fin_q | {end_process_d, end_process_c,
                       end_process_b, end_process_a};
    end
    if (start_process && rest) begin
      fin_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (&fin_q && !start_process) begin
          addr_d  = BASE_ADDR;
          cnt_d   = CNT_INIT;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = mem_data;
        vld_d   = 1'b1;
        last_d  = (cnt_q == '0);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          vld_d  = 1'b0;
          last_d = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (start_process) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == S_ISSUE);
    busy      = (state_q == S_ISSUE)   ||
                (state_q == S_CAPTURE) ||
                (state_q == S_HOLD);
    done      = (state_q == S_DONE);
  end

  assign mem_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed vector table plus hand sequences for
// backpressure, restart, partial finish, wrap and asynchronous abort.
module tb_result_drain;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_process = 1'b0;
  logic [3:0]  endp = 4'h0;
  logic        out_ready = 1'b1;

  logic [15:0] mem [0:65535];

  logic        m_rd, m_vld, m_last, m_busy, m_done;
  logic [15:0] m_addr, m_data;
  logic [15:0] m_md = 16'h0;
  logic        w_rd, w_vld, w_last, w_busy, w_done;
  logic [15:0] w_addr, w_data;
  logic [15:0] w_md = 16'h0;
  logic        s_rd, s_vld, s_last, s_busy, s_done;
  logic [15:0] s_addr, s_data;
  logic [15:0] s_md = 16'h0;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  result_drain #(
    .ADDR_W(16), .DATA_W(16),
    .BASE_ADDR(16'd32), .NUM_WORDS(4)
  ) u_main (
    .clock(clock), .reset_n(reset_n),
    .start_process(start_process),
    .end_process_a(endp[0]), .end_process_b(endp[1]),
    .end_process_c(endp[2]), .end_process_d(endp[3]),
    .mem_rd_en(m_rd), .mem_addr(m_addr), .mem_data(m_md),
    .out_data(m_data), .out_valid(m_vld),
    .out_ready(out_ready), .out_last(m_last),
    .busy(m_busy), .done(m_done)
  );

  result_drain #(
    .ADDR_W(16), .DATA_W(16),
    .BASE_ADDR(16'hFFFE), .NUM_WORDS(3)
  ) u_wrap (
    .clock(clock), .reset_n(reset_n),
    .start_process(start_process),
    .end_process_a(endp[0]), .end_process_b(endp[1]),
    .end_process_c(endp[2]), .end_process_d(endp[3]),
    .mem_rd_en(w_rd), .mem_addr(w_addr), .mem_data(w_md),
    .out_data(w_data), .out_valid(w_vld),
    .out_ready(out_ready), .out_last(w_last),
    .busy(w_busy), .done(w_done)
  );

  result_drain #(
    .ADDR_W(16), .DATA_W(16),
    .BASE_ADDR(16'd100), .NUM_WORDS(1)
  ) u_single (
    .clock(clock), .reset_n(reset_n),
    .start_process(start_process),
    .end_process_a(endp[0]), .end_process_b(endp[1]),
    .end_process_c(endp[2]), .end_process_d(endp[3]),
    .mem_rd_en(s_rd), .mem_addr(s_addr), .mem_data(s_md),
    .out_data(s_data), .out_valid(s_vld),
    .out_ready(out_ready), .out_last(s_last),
    .busy(s_busy), .done(s_done)
  );

  // one-cycle read latency memory per instance
  always @(posedge clock) begin
    if (m_rd) m_md <= mem[m_addr];
    if (w_rd) w_md <= mem[w_addr];
    if (s_rd) s_md <= mem[s_addr];
  end

  logic [15:0] wq [$];
  logic        s_got = 1'b0;
  logic [15:0] s_word = 16'h0;
  logic        s_lastv = 1'b0;

  always @(negedge clock) begin
    if (reset_n && w_rd && wq.size() < 3) wq.push_back(w_addr);
    if (reset_n && s_vld && out_ready && !s_got) begin
      s_got   = 1'b1;
      s_word  = s_data;
      s_lastv = s_last;
    end
  end

  typedef struct {
    logic        st;
    logic [3:0]  e;
    logic        r;
    logic        rd;
    logic [15:0] a;
    logic        vl;
    logic [15:0] d;
    logic        l;
    logic        b;
    logic        dn;
  } vec_t;

  vec_t        tbl [21];
  logic [15:0] exp_w [4];
  logic [15:0] wexp [3];

  function automatic vec_t V(
    input logic st, input logic [3:0] e, input logic r,
    input logic rd, input logic [15:0] a, input logic vl,
    input logic [15:0] d, input logic l, input logic b,
    input logic dn);
    vec_t v;
    v.st = st; v.e = e; v.r = r; v.rd = rd; v.a = a;
    v.vl = vl; v.d = d; v.l = l; v.b = b; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic recv(input int n, input int sidx,
                      input int sn, input bit poke);
    int k = 0;
    int stalled = 0;
    int rds = 0;
    int cyc = 0;
    while (k < n && cyc < 200) begin
      if (poke) begin
        if (k >= 1 && k < 3) begin
          start_process = 1'b1;
          endp = ~endp;
        end else if (k >= 3) begin
          start_process = 1'b0;
          endp = 4'h0;
        end
      end
      if (k == sidx && m_vld && stalled < sn) begin
        out_ready = 1'b0;
        stalled++;
        chk("stall_data", m_data, exp_w[k]);
        chk("stall_last", m_last, 0);
      end else begin
        out_ready = 1'b1;
      end
      if (m_rd) rds++;
      if (m_vld && out_ready) begin
        chk("word", m_data, exp_w[k]);
        chk("last", m_last, (k == n - 1) ? 1 : 0);
        k++;
      end
      if (k < n) tick();
      cyc++;
    end
    chk("words_recv", k, n);
    chk("reads_issued", rds, n);
    chk("stall_cycles", stalled, sn < 0 ? 0 : sn);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_rd"},   m_rd,   0);
    chk({tag, "_addr"}, m_addr, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_vld"},  m_vld,  0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int c;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[32] = 16'h0011; mem[33] = 16'h0022;
    mem[34] = 16'h0033; mem[35] = 16'h0044;
    mem[100] = 16'hBEEF;
    wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000;

    // run 1 cycle by cycle, then two cycles of restart
    tbl[0]  = V(0, 4'h1, 1, 0, 16'd0,  0, 16'h0,    0, 0, 0);
    tbl[1]  = V(0, 4'h0, 1, 0, 16'd0,  0, 16'h0,    0, 0, 0);
    tbl[2]  = V(0, 4'h2, 1, 0, 16'd0,  0, 16'h0,    0, 0, 0);
    tbl[3]  = V(0, 4'h4, 1, 0, 16'd0,  0, 16'h0,    0, 0, 0);
    tbl[4]  = V(0, 4'h8, 1, 0, 16'd0,  0, 16'h0,    0, 0, 0);
    tbl[5]  = V(0, 4'h0, 1, 1, 16'd32, 0, 16'h0,    0, 1, 0);
    tbl[6]  = V(0, 4'h0, 1, 0, 16'd32, 0, 16'h0,    0, 1, 0);
    tbl[7]  = V(0, 4'h0, 1, 0, 16'd32, 1, 16'h0011, 0, 1, 0);
    tbl[8]  = V(0, 4'h0, 1, 1, 16'd33, 0, 16'h0,    0, 1, 0);
    tbl[9]  = V(0, 4'h0, 1, 0, 16'd33, 0, 16'h0,    0, 1, 0);
    tbl[10] = V(0, 4'h0, 1, 0, 16'd33, 1, 16'h0022, 0, 1, 0);
    tbl[11] = V(0, 4'h0, 1, 1, 16'd34, 0, 16'h0,    0, 1, 0);
    tbl[12] = V(0, 4'h0, 1, 0, 16'd34, 0, 16'h0,    0, 1, 0);
    tbl[13] = V(0, 4'h0, 1, 0, 16'd34, 1, 16'h0033, 0, 1, 0);
    tbl[14] = V(0, 4'h0, 1, 1, 16'd35, 0, 16'h0,    0, 1, 0);
    tbl[15] = V(0, 4'h0, 1, 0, 16'd35, 0, 16'h0,    0, 1, 0);
    tbl[16] = V(0, 4'h0, 1, 0, 16'd35, 1, 16'h0044, 1, 1, 0);
    tbl[17] = V(0, 4'h0, 1, 0, 16'd35, 0, 16'h0,    0, 0, 1);
    tbl[18] = V(0, 4'h0, 1, 0, 16'd35, 0, 16'h0,    0, 0, 1);
    tbl[19] = V(1, 4'h0, 1, 0, 16'd35, 0, 16'h0,    0, 0, 0);
    tbl[20] = V(1, 4'h0, 1, 0, 16'd35, 0, 16'h0,    0, 0, 0);

    #12;
    check_reset_outs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 21; i++) begin
      start_process = tbl[i].st;
      endp          = tbl[i].e;
      out_ready     = tbl[i].r;
      tick();
      chk($sformatf("v%0d_rd", i),   m_rd,   tbl[i].rd);
      chk($sformatf("v%0d_addr", i), m_addr, tbl[i].a);
      chk($sformatf("v%0d_vld", i),  m_vld,  tbl[i].vl);
      if (tbl[i].vl) begin
        chk($sformatf("v%0d_data", i), m_data, tbl[i].d);
        chk($sformatf("v%0d_last", i), m_last, tbl[i].l);
      end
      chk($sformatf("v%0d_busy", i), m_busy, tbl[i].b);
      chk($sformatf("v%0d_done", i), m_done, tbl[i].dn);
    end

    chk("wrap_reads", wq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_addr%0d", i),
          (i < wq.size()) ? {16'h0, wq[i]} : 32'hDEADBEEF,
          {16'h0, wexp[i]});
    end
    chk("single_seen", s_got, 1);
    chk("single_word", s_word, 16'hBEEF);
    chk("single_last", s_lastv, 1);

    // run 2: new data, start and finish inputs churned mid-sweep
    mem[32] = 16'hA000; mem[33] = 16'hA001;
    mem[34] = 16'hA002; mem[35] = 16'hA003;
    for (int i = 0; i < 4; i++) exp_w[i] = mem[32 + i];
    start_process = 1'b0;
    endp = 4'hF;
    tick();
    endp = 4'h0;
    recv(4, -1, 0, 1'b1);
    tick();
    chk("run2_done", m_done, 1);
    chk("run2_busy", m_busy, 0);

    // run 3: backpressure on word 1
    start_process = 1'b1;
    tick();
    chk("restart_done_clr", m_done, 0);
    start_process = 1'b0;
    mem[32] = 16'h0011; mem[33] = 16'h0022;
    mem[34] = 16'h0033; mem[35] = 16'h0044;
    for (int i = 0; i < 4; i++) exp_w[i] = mem[32 + i];
    endp = 4'hF;
    tick();
    endp = 4'h0;
    recv(4, 1, 5, 1'b0);
    tick();
    chk("run3_done", m_done, 1);

    // partial finish: three cores only
    start_process = 1'b1;
    tick();
    start_process = 1'b0;
    endp = 4'h1; tick();
    endp = 4'h2; tick();
    endp = 4'h4; tick();
    endp = 4'h0;
    bad = 0;
    repeat (100) begin
      tick();
      if (m_rd || m_busy) bad++;
    end
    chk("partial_idle", bad, 0);
    endp = 4'h8;
    tick();
    endp = 4'h0;
    chk("late_d_rd0", m_rd, 0);
    tick();
    chk("late_d_rd1", m_rd, 1);
    chk("late_d_addr", m_addr, 16'd32);
    recv(4, -1, 0, 1'b0);
    tick();
    chk("run4_done", m_done, 1);

    // asynchronous abort while a word is held
    start_process = 1'b1;
    tick();
    start_process = 1'b0;
    endp = 4'hF;
    tick();
    endp = 4'h0;
    out_ready = 1'b0;
    c = 0;
    while (!m_vld && c < 20) begin
      tick();
      c++;
    end
    chk("abort_hold_vld", m_vld, 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outs("abort");
    #20;
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
